score_bcd_encoder: RTL and testbench

Sequential binary-to-BCD encoder that turns a signed player score into four decimal digit nibbles plus a sign flag. It drives the 4-bit `c3..c0` inputs of the 7-segment hex decoders on the score display. Conversion uses iterative shift-add-3 (double dabble), one bit per clock. Results are held steady between conversions so the displays never flicker mid-update.

---
 rtl/score_bcd_encoder_if.sv | 26 ++
 rtl/score_bcd_encoder.sv | 151 +++++++++++++++
 tb/tb_score_bcd_encoder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/score_bcd_encoder_if.sv
// Score display bus: conversion request plus the held BCD result.
// The encoder takes the slave side; whoever requests conversions takes the master side.
interface score_bcd_encoder_if #(
   parameter int unsigned WIDTH = 16
) ();
   logic             start;
   logic [WIDTH-1:0] value;
   logic [3:0]       digit3;
   logic [3:0]       digit2;
   logic [3:0]       digit1;
   logic [3:0]       digit0;
   logic             neg;
   logic             overflow;
   logic             busy;
   logic             done;

   modport master (
      output start, value,
      input  digit3, digit2, digit1, digit0, neg, overflow, busy, done
   );

   modport slave (
      input  start, value,
      output digit3, digit2, digit1, digit0, neg, overflow, busy, done
   );
endinterface

// File: rtl/score_bcd_encoder.sv
// Signed score to BCD digits via double dabble, one magnitude bit per clock.
// Displayed digits, sign and overflow only change on entry to DONE.
module score_bcd_encoder #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned DIGITS = 4
) (
   input logic           clock,
   input logic           resetn,
   score_bcd_encoder_if.slave bus
);

   function automatic int unsigned pow10_minus1(input int unsigned n);
      int unsigned p;
      p = 1;
      for (int unsigned i = 0; i < n; i++) p = p * 10;
      return p - 1;
   endfunction

   localparam int unsigned SW  = 4 * DIGITS;
   localparam int unsigned CW  = $clog2(WIDTH + 1);
   localparam int unsigned MAX = pow10_minus1(DIGITS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic [WIDTH-1:0] mag_q, mag_d;
   logic [SW-1:0]    scratch_q, scratch_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sign_pend_q, sign_pend_d;
   logic             ovf_pend_q, ovf_pend_d;
   logic [SW-1:0]    digits_q, digits_d;
   logic             neg_q, neg_d;
   logic             overflow_q, overflow_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] abs_val;
   logic [SW-1:0]    adj;

   // State and datapath registers; reset wins over any conversion in flight
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q     <= IDLE;
         value_q     <= '0;
         mag_q       <= '0;
         scratch_q   <= '0;
         cnt_q       <= '0;
         sign_pend_q <= 1'b0;
         ovf_pend_q  <= 1'b0;
         digits_q    <= '0;
         neg_q       <= 1'b0;
         overflow_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         value_q     <= value_d;
         mag_q       <= mag_d;
         scratch_q   <= scratch_d;
         cnt_q       <= cnt_d;
         sign_pend_q <= sign_pend_d;
         ovf_pend_q  <= ovf_pend_d;
         digits_q    <= digits_d;
         neg_q       <= neg_d;
         overflow_q  <= overflow_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next state, datapath and registered outputs
   always_comb begin
      state_d     = state_q;
      value_d     = value_q;
      mag_d       = mag_q;
      scratch_d   = scratch_q;
      cnt_d       = cnt_q;
      sign_pend_d = sign_pend_q;
      ovf_pend_d  = ovf_pend_q;
      digits_d    = digits_q;
      neg_d       = neg_q;
      overflow_d  = overflow_q;
      adj         = '0;

      // Most negative input wraps to exactly 2^(WIDTH-1) as an unsigned magnitude
      abs_val = value_q[WIDTH-1] ? WIDTH'(~value_q + WIDTH'(1)) : value_q;

      for (int i = 0; i < int'(DIGITS); i++) begin
         adj[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ? scratch_q[4*i +: 4] + 4'd3
                                                       : scratch_q[4*i +: 4];
      end

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               value_d = bus.value;
               state_d = LOAD;
            end
         end
         LOAD: begin
            sign_pend_d = value_q[WIDTH-1];
            if (32'(abs_val) > MAX) begin
               mag_d      = WIDTH'(MAX);
               ovf_pend_d = 1'b1;
            end else begin
               mag_d      = abs_val;
               ovf_pend_d = 1'b0;
            end
            scratch_d = '0;
            cnt_d     = CW'(WIDTH);
            state_d   = SHIFT;
         end
         SHIFT: begin
            scratch_d = {adj[SW-2:0], mag_q[WIDTH-1]};
            mag_d     = {mag_q[WIDTH-2:0], 1'b0};
            cnt_d     = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Result registers load on the edge that enters DONE so they appear with done
      if (state_d == DONE && state_q != DONE) begin
         digits_d   = scratch_d;
         neg_d      = sign_pend_d;
         overflow_d = ovf_pend_d;
      end

      busy_d = (state_d == LOAD) || (state_d == SHIFT);
      done_d = (state_d == DONE);
   end

   assign bus.digit3   = digits_q[15:12];
   assign bus.digit2   = digits_q[11:8];
   assign bus.digit1   = digits_q[7:4];
   assign bus.digit0   = digits_q[3:0];
   assign bus.neg      = neg_q;
   assign bus.overflow = overflow_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_score_bcd_encoder.sv
// Scoreboard bench for score_bcd_encoder: expected results queued at accept, checked on done.
module tb_score_bcd_encoder;

   typedef struct {
      logic [15:0] dig;
      logic        neg;
      logic        ovf;
      int          cyc;
   } exp_t;

   logic clock  = 1'b0;
   logic resetn = 1'b0;
   int   cyc    = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   acc_cyc  = 0;
   exp_t sb[$];
   exp_t mon_e;
   logic [17:0] last_out = '0;

   score_bcd_encoder_if #(.WIDTH(16)) bus ();

   score_bcd_encoder #(.WIDTH(16), .DIGITS(4)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [15:0] v);
      exp_t e;
      int   m;
      m = int'($signed(v));
      if (m < 0) m = -m;
      e.neg = v[15];
      e.ovf = (m > 9999);
      if (e.ovf) m = 9999;
      e.dig = {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
      e.cyc = 0;
      return e;
   endfunction

   function automatic logic [17:0] cur_out();
      return {bus.digit3, bus.digit2, bus.digit1, bus.digit0, bus.neg, bus.overflow};
   endfunction

   // Monitor: pop on done, otherwise outputs must hold their last reported value
   always @(negedge clock) begin
      if (!resetn) begin
         last_out = '0;
      end else if (bus.done) begin
         if (sb.size() == 0) begin
            check_val("spurious_done", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check_val("digits", 32'({bus.digit3, bus.digit2, bus.digit1, bus.digit0}), 32'(mon_e.dig));
            check_val("neg", 32'(bus.neg), 32'(mon_e.neg));
            check_val("overflow", 32'(bus.overflow), 32'(mon_e.ovf));
            check_val("done_cycle", 32'(cyc), 32'(mon_e.cyc));
            check_val("busy_in_done", 32'(bus.busy), 32'd0);
         end
         last_out = cur_out();
      end else begin
         check_val("hold", 32'(cur_out()), 32'(last_out));
      end
   end

   task automatic tick_to(input int c);
      while (cyc < c) @(negedge clock);
      #1;
   endtask

   task automatic accept(input logic [15:0] v);
      exp_t e;
      @(negedge clock);
      #1;
      bus.start = 1'b1;
      bus.value = v;
      e = model(v);
      e.cyc = cyc + 18;
      sb.push_back(e);
      acc_cyc = cyc + 1;
      @(negedge clock);
      #1;
      bus.start = 1'b0;
      check_val("busy_rise", 32'(bus.busy), 32'd1);
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clock);
      #1;
      if (sb.size() != 0) begin
         check_val("timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
      repeat (2) @(negedge clock);
      #1;
   endtask

   initial begin
      bus.start = 1'b1;
      bus.value = 16'd1234;
      repeat (2) @(negedge clock);
      #1;
      resetn    = 1'b1;
      bus.start = 1'b0;
      check_val("rst_outputs", 32'(cur_out()), 32'd0);
      check_val("rst_busy", 32'(bus.busy), 32'd0);
      check_val("rst_done", 32'(bus.done), 32'd0);
      @(negedge clock);
      #1;
      check_val("rst_idle_busy", 32'(bus.busy), 32'd0);

      accept(16'd1234);  wait_drain(40);
      accept(16'hFDA8);  wait_drain(40);
      accept(16'd0);     wait_drain(40);
      accept(16'd9999);  wait_drain(40);
      accept(16'd12000); wait_drain(40);
      accept(16'h8000);  wait_drain(40);

      // Starts during SHIFT and in the DONE cycle must be dropped
      accept(16'd1234);
      tick_to(acc_cyc + 5);
      bus.start = 1'b1;
      bus.value = 16'd4321;
      @(negedge clock);
      #1;
      bus.start = 1'b0;
      tick_to(acc_cyc + 17);
      bus.start = 1'b1;
      bus.value = 16'd4321;
      @(negedge clock);
      #1;
      bus.start = 1'b0;
      repeat (30) @(negedge clock);
      #1;
      check_val("no_second_done", 32'(sb.size()), 32'd0);

      // Reset mid-conversion aborts it without a done pulse
      accept(16'd5678);
      tick_to(acc_cyc + 9);
      resetn = 1'b0;
      sb.delete();
      @(negedge clock);
      #1;
      resetn = 1'b1;
      check_val("abort_busy", 32'(bus.busy), 32'd0);
      check_val("abort_outputs", 32'(cur_out()), 32'd0);
      check_val("abort_done", 32'(bus.done), 32'd0);
      repeat (30) @(negedge clock);
      #1;
      accept(16'd42);
      wait_drain(40);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
